// File: rtl/input_conditioner.sv
// Switch and push-button conditioner for the LSU input-peripheral bank.
// Synchronises pads, debounces, and raises press pulses and sticky flags.
module input_conditioner #(
  parameter int SW_WIDTH     = 32,
  parameter int BTN_WIDTH    = 4,
  parameter int SW_TICK      = 500000,
  parameter int BTN_DEBOUNCE = 250000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SW_WIDTH-1:0]  i_sw_raw,
  input  logic [BTN_WIDTH-1:0] i_btn_raw,
  input  logic [BTN_WIDTH-1:0] i_btn_clr,
  output logic [SW_WIDTH-1:0]  o_sw_level,
  output logic [BTN_WIDTH-1:0] o_btn_level,
  output logic [BTN_WIDTH-1:0] o_btn_rise,
  output logic [BTN_WIDTH-1:0] o_btn_sticky
);

  localparam int CW = (BTN_DEBOUNCE > 1) ? $clog2(BTN_DEBOUNCE) : 1;
  localparam int TW = (SW_TICK > 1) ? $clog2(SW_TICK) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(BTN_DEBOUNCE - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(SW_TICK - 1);

  // Synchroniser stages.
  logic [SW_WIDTH-1:0]  r_sw_s1;
  logic [SW_WIDTH-1:0]  r_sw_s2;
  logic [BTN_WIDTH-1:0] r_btn_s1;
  logic [BTN_WIDTH-1:0] r_btn_s2;

  // Button debounce state.
  logic [CW-1:0]        r_btn_cnt [BTN_WIDTH];
  logic [BTN_WIDTH-1:0] r_btn_level;
  logic [BTN_WIDTH-1:0] r_btn_rise;
  logic [BTN_WIDTH-1:0] r_btn_sticky;

  // Switch debounce state.
  logic [TW-1:0]        r_tick_cnt;
  logic [SW_WIDTH-1:0]  r_sw_samp;
  logic [SW_WIDTH-1:0]  r_sw_level;

  // Combinational helpers.
  logic [BTN_WIDTH-1:0] w_btn_diff;
  logic [BTN_WIDTH-1:0] w_btn_done;
  logic [BTN_WIDTH-1:0] w_btn_set;
  logic                 w_tick;
  logic                 w_sw_stable;

  // Two-flop synchronisers on every pad input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= i_sw_raw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= i_btn_raw;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Per-button flip decision: differing level that has run a full window.
  always_comb begin
    w_btn_diff = r_btn_s2 ^ r_btn_level;
    w_btn_done = '0;
    for (int b = 0; b < BTN_WIDTH; b++) begin
      w_btn_done[b] = w_btn_diff[b] && (r_btn_cnt[b] == CNT_MAX);
    end
    w_btn_set = w_btn_done & r_btn_s2;
  end

  // Button debounce counters and accepted levels.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_level <= '0;
      for (int b = 0; b < BTN_WIDTH; b++) begin
        r_btn_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < BTN_WIDTH; b++) begin
        if (!w_btn_diff[b]) begin
          r_btn_cnt[b] <= '0;
        end else if (w_btn_done[b]) begin
          r_btn_cnt[b]   <= '0;
          r_btn_level[b] <= r_btn_s2[b];
        end else begin
          r_btn_cnt[b] <= r_btn_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Press pulse, registered alongside the level flip.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_rise <= '0;
    end else begin
      r_btn_rise <= w_btn_set;
    end
  end

  // Sticky flags; a press (including one whose pulse is showing) beats a clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_sticky <= '0;
    end else begin
      r_btn_sticky <= (r_btn_sticky & ~i_btn_clr)
                    | w_btn_set
                    | r_btn_rise;
    end
  end

  assign w_tick      = (r_tick_cnt == TICK_MAX);
  assign w_sw_stable = (r_sw_s2 == r_sw_samp);

  // Shared free-running sample tick for the switch bank.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Accept the switch vector only when two consecutive ticks agree.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sw_samp  <= '0;
      r_sw_level <= '0;
    end else if (w_tick) begin
      r_sw_samp <= r_sw_s2;
      if (w_sw_stable) begin
        r_sw_level <= r_sw_s2;
      end
    end
  end

  assign o_sw_level   = r_sw_level;
  assign o_btn_level  = r_btn_level;
  assign o_btn_rise   = r_btn_rise;
  assign o_btn_sticky = r_btn_sticky;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner.
// Small debounce/tick parameters, hand-computed expectations.
module tb_input_conditioner;

  localparam int SWW = 32;
  localparam int BW  = 4;

  logic           clk;
  logic           rst;
  logic [SWW-1:0] sw_raw;
  logic [BW-1:0]  btn_raw;
  logic [BW-1:0]  btn_clr;
  logic [SWW-1:0] sw_level;
  logic [BW-1:0]  btn_level;
  logic [BW-1:0]  btn_rise;
  logic [BW-1:0]  btn_sticky;

  int n_run;
  int n_fail;
  int cyc;
  int n0;
  int t1;
  int t2;
  int t3;
  logic [BW-1:0] seen;

  input_conditioner #(
    .SW_WIDTH    (SWW),
    .BTN_WIDTH   (BW),
    .SW_TICK     (8),
    .BTN_DEBOUNCE(4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sw_raw    (sw_raw),
    .i_btn_raw   (btn_raw),
    .i_btn_clr   (btn_clr),
    .o_sw_level  (sw_level),
    .o_btn_level (btn_level),
    .o_btn_rise  (btn_rise),
    .o_btn_sticky(btn_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk_btn(input string tag,
                         input logic [BW-1:0] lv,
                         input logic [BW-1:0] rs,
                         input logic [BW-1:0] st);
    chk({tag, ".level"},  32'(btn_level),  32'(lv));
    chk({tag, ".rise"},   32'(btn_rise),   32'(rs));
    chk({tag, ".sticky"}, 32'(btn_sticky), 32'(st));
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    sw_raw  = 32'hFFFF_FFFF;
    btn_raw = 4'hF;
    btn_clr = 4'h0;

    // Reset held for 3 edges with all pads high.
    step(1);
    chk_btn("rst1", 4'h0, 4'h0, 4'h0);
    chk("rst1.sw", sw_level, 32'h0);
    step(2);
    chk_btn("rst3", 4'h0, 4'h0, 4'h0);
    chk("rst3.sw", sw_level, 32'h0);

    rst     = 1'b0;
    sw_raw  = 32'h0;
    btn_raw = 4'h0;
    cyc     = 0;
    step(1);
    chk_btn("post_rst", 4'h0, 4'h0, 4'h0);
    chk("post_rst.sw", sw_level, 32'h0);

    // Clean press of button 0: level after 6 edges.
    btn_raw = 4'b0001;
    step(5);
    chk_btn("press.e5", 4'h0, 4'h0, 4'h0);
    step(1);
    chk_btn("press.e6", 4'b0001, 4'b0001, 4'b0001);
    step(1);
    chk_btn("press.e7", 4'b0001, 4'b0000, 4'b0001);

    // Three-cycle glitch on button 2 is rejected.
    btn_raw = 4'b0101;
    step(3);
    btn_raw = 4'b0001;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen = seen | ((btn_level | btn_rise | btn_sticky) & 4'b0100);
    end
    chk("glitch.seen", 32'(seen), 32'h0);
    chk_btn("glitch.end", 4'b0001, 4'b0000, 4'b0001);

    // Clear collides with the visible rise pulse of button 1.
    btn_raw = 4'b0011;
    step(6);
    chk_btn("coll.rise", 4'b0011, 4'b0010, 4'b0011);
    btn_clr = 4'b0010;
    step(1);
    btn_clr = 4'b0000;
    chk_btn("coll.hold", 4'b0011, 4'b0000, 4'b0011);
    step(1);
    chk("coll.hold2", 32'(btn_sticky), 32'(4'b0011));
    btn_clr = 4'b0010;
    step(1);
    btn_clr = 4'b0000;
    chk("clr.lone", 32'(btn_sticky), 32'(4'b0001));
    btn_clr = 4'b0100;
    step(1);
    btn_clr = 4'b0000;
    chk("clr.noop", 32'(btn_sticky), 32'(4'b0001));

    // Switch acceptance: tick edges are cyc multiples of 8.
    while (cyc % 8 != 2) step(1);
    n0 = cyc;
    t1 = n0 + 6;
    t2 = t1 + 8;
    sw_raw = 32'hA5A5_A5A5;
    while (cyc < t1) step(1);
    chk("sw.t1", sw_level, 32'h0);
    while (cyc < t2 - 1) step(1);
    chk("sw.t2m1", sw_level, 32'h0);
    step(1);
    chk("sw.t2", sw_level, 32'hA5A5_A5A5);

    // Bit 3 wrong at one tick: accepted one period late.
    while (cyc % 8 != 2) step(1);
    n0 = cyc;
    t1 = n0 + 6;
    t2 = t1 + 8;
    t3 = t2 + 8;
    sw_raw = 32'h0000_FFF7;
    while (cyc < t1) step(1);
    sw_raw = 32'h0000_FFFF;
    chk("bnc.t1", sw_level, 32'hA5A5_A5A5);
    while (cyc < t2) step(1);
    chk("bnc.t2", sw_level, 32'hA5A5_A5A5);
    while (cyc < t3 - 1) step(1);
    chk("bnc.t3m1", sw_level, 32'hA5A5_A5A5);
    step(1);
    chk("bnc.t3", sw_level, 32'h0000_FFFF);

    // Release produces no rise pulse.
    btn_raw = 4'b0000;
    step(5);
    chk_btn("rel.e5", 4'b0011, 4'b0000, 4'b0001);
    step(1);
    chk_btn("rel.e6", 4'b0000, 4'b0000, 4'b0001);

    // Reset while button-0 counter is at 2.
    btn_raw = 4'b0001;
    step(4);
    chk("mid.pre", 32'(btn_level), 32'h0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_btn("mid.rst", 4'h0, 4'h0, 4'h0);
    chk("mid.sw", sw_level, 32'h0);
    step(5);
    chk_btn("mid.e5", 4'h0, 4'h0, 4'h0);
    step(1);
    chk_btn("mid.e6", 4'b0001, 4'b0001, 4'b0001);
    step(1);
    chk_btn("mid.e7", 4'b0001, 4'b0000, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
